// File: rtl/downscale_pkg.sv
// Shared types and elaboration-time helpers for the
// memory-to-stream image downscaler.
package downscale_pkg;

  localparam int FRAC_BITS_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    COORD,
    RD_ISSUE,
    RD_WAIT,
    CALC,
    WRITE,
    DONE
  } state_e;

  function automatic int unsigned rnd_div(
    input int unsigned n,
    input int unsigned d
  );
    return (n + d / 2) / d;
  endfunction

  function automatic int unsigned ratio(
    input int unsigned src,
    input int unsigned dst,
    input int unsigned frac
  );
    return rnd_div((src - 1) << frac, dst - 1);
  endfunction

endpackage

// File: rtl/bilinear_mac.sv
// Combinational bilinear blend of four neighbours with
// round-to-nearest and saturation.
module bilinear_mac #(
  parameter int PIX_W     = 8,
  parameter int FRAC_BITS = 12
) (
  input  logic [PIX_W-1:0]     a_i,
  input  logic [PIX_W-1:0]     b_i,
  input  logic [PIX_W-1:0]     c_i,
  input  logic [PIX_W-1:0]     d_i,
  input  logic [FRAC_BITS-1:0] wx_i,
  input  logic [FRAC_BITS-1:0] wy_i,
  output logic [PIX_W-1:0]     r_o
);

  localparam int F  = FRAC_BITS;
  localparam int TW = PIX_W + F + 1;
  localparam int SW = PIX_W + 2 * F + 3;

  localparam logic [F:0]    ONE = {1'b1, {F{1'b0}}};
  localparam logic [SW-1:0] RND = SW'(1) << (2 * F - 1);

  logic [F:0]    iwx;
  logic [F:0]    iwy;
  logic [TW-1:0] top;
  logic [TW-1:0] bot;
  logic [SW-1:0] acc;
  logic [SW-1:0] shr;

  always_comb begin
    iwx = ONE - {1'b0, wx_i};
    iwy = ONE - {1'b0, wy_i};
    top = TW'(a_i) * TW'(iwx) + TW'(b_i) * TW'(wx_i);
    bot = TW'(c_i) * TW'(iwx) + TW'(d_i) * TW'(wx_i);
    acc = SW'(top) * SW'(iwy) + SW'(bot) * SW'(wy_i) + RND;
    shr = acc >> (2 * F);
    r_o = (|shr[SW-1:PIX_W]) ? '1 : shr[PIX_W-1:0];
  end

endmodule

// File: rtl/downscale_mem_stream.sv
// Frame downscaler: fetches source neighbours one read
// at a time and streams interpolated destination pixels.
module downscale_mem_stream
  import downscale_pkg::*;
#(
  parameter int SRC_W     = 32,
  parameter int SRC_H     = 32,
  parameter int DST_W     = 16,
  parameter int DST_H     = 16,
  parameter int PIX_W     = 8,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           mode,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_req,
  output logic [$clog2(SRC_W*SRC_H)-1:0] rd_addr,
  input  logic                           rd_valid,
  input  logic [PIX_W-1:0]               rd_data,
  output logic                           wr_en,
  output logic [$clog2(DST_W*DST_H)-1:0] wr_addr,
  output logic [PIX_W-1:0]               wr_data
);

  localparam int F   = FRAC_BITS;
  localparam int RAW = $clog2(SRC_W * SRC_H);
  localparam int WAW = $clog2(DST_W * DST_H);
  localparam int XW  = $clog2(SRC_W) + F + 1;
  localparam int YW  = $clog2(SRC_H) + F + 1;
  localparam int CCW = $clog2(DST_W);
  localparam int RCW = $clog2(DST_H);

  localparam int unsigned X_RATIO = ratio(SRC_W, DST_W, F);
  localparam int unsigned Y_RATIO = ratio(SRC_H, DST_H, F);

  state_e                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [XW-1:0]             xs_q, xs_d;
  logic [YW-1:0]             ys_q, ys_d;
  logic [CCW-1:0]            col_q, col_d;
  logic [RCW-1:0]            row_q, row_d;
  logic [WAW-1:0]            wa_q, wa_d;
  logic [1:0]                nb_q, nb_d;
  logic [3:0][PIX_W-1:0]     pix_q, pix_d;
  logic [PIX_W-1:0]          res_q, res_d;

  logic [F-1:0]   wx, wy;
  logic [RAW-1:0] xl, xh, yl, yh;
  logic [RAW-1:0] row_a, col_a;
  logic           sel_x, sel_y;
  logic           last_col, last_row;
  logic [PIX_W-1:0] mac_r;

  assign wx = xs_q[F-1:0];
  assign wy = ys_q[F-1:0];

  // Neighbour index bit 0 picks the right column, bit 1 the lower row.
  always_comb begin
    xl = RAW'(xs_q[XW-1:F]);
    if (xl > RAW'(SRC_W - 1)) xl = RAW'(SRC_W - 1);
    xh = (xl == RAW'(SRC_W - 1)) ? xl : xl + RAW'(1);
    yl = RAW'(ys_q[YW-1:F]);
    if (yl > RAW'(SRC_H - 1)) yl = RAW'(SRC_H - 1);
    yh = (yl == RAW'(SRC_H - 1)) ? yl : yl + RAW'(1);
    sel_x = mode_q ? wx[F-1] : nb_q[0];
    sel_y = mode_q ? wy[F-1] : nb_q[1];
    col_a = sel_x ? xh : xl;
    row_a = sel_y ? yh : yl;
  end

  bilinear_mac #(
    .PIX_W    (PIX_W),
    .FRAC_BITS(F)
  ) u_mac (
    .a_i (pix_q[0]),
    .b_i (pix_q[1]),
    .c_i (pix_q[2]),
    .d_i (pix_q[3]),
    .wx_i(wx),
    .wy_i(wy),
    .r_o (mac_r)
  );

  assign last_col = (col_q == CCW'(DST_W - 1));
  assign last_row = (row_q == RCW'(DST_H - 1));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    col_d   = col_q;
    row_d   = row_q;
    wa_d    = wa_q;
    nb_d    = nb_q;
    pix_d   = pix_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COORD;
          mode_d  = mode;
          xs_d    = '0;
          ys_d    = '0;
          col_d   = '0;
          row_d   = '0;
          wa_d    = '0;
        end
      end
      COORD: begin
        nb_d    = 2'd0;
        state_d = RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (rd_valid) begin
          pix_d[nb_q] = rd_data;
          if (mode_q || nb_q == 2'd3) begin
            state_d = CALC;
          end else begin
            nb_d    = nb_q + 2'd1;
            state_d = RD_ISSUE;
          end
        end
      end
      CALC: begin
        res_d   = mode_q ? pix_q[0] : mac_r;
        state_d = WRITE;
      end
      WRITE: begin
        wa_d = wa_q + WAW'(1);
        if (last_col) begin
          col_d = '0;
          xs_d  = '0;
          row_d = row_q + RCW'(1);
          ys_d  = ys_q + YW'(Y_RATIO);
        end else begin
          col_d = col_q + CCW'(1);
          xs_d  = xs_q + XW'(X_RATIO);
        end
        state_d = (last_col && last_row) ? DONE : COORD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      xs_q    <= '0;
      ys_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wa_q    <= '0;
      nb_q    <= '0;
      pix_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wa_q    <= wa_d;
      nb_q    <= nb_d;
      pix_q   <= pix_d;
      res_q   <= res_d;
    end
  end

  // Strobes are cut by abort so nothing escapes in the aborting cycle.
  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign done    = (state_q == DONE);
  assign rd_req  = (state_q == RD_ISSUE) && !abort;
  assign wr_en   = (state_q == WRITE) && !abort;
  assign rd_addr = rd_req ? row_a * RAW'(SRC_W) + col_a : '0;
  assign wr_addr = wr_en ? wa_q : '0;
  assign wr_data = wr_en ? res_q : '0;

endmodule
